// File: rtl/rv32i_ctrl_alu_dmem_if.sv
// rv32i_ctrl_alu_dmem_if: decoded-instruction inputs and control/data outputs of the execute cluster
// master drives opcode/func/operands/store data/address; slave drives result, load data, ALUop and all strobes
interface rv32i_ctrl_alu_dmem_if;
  logic [6:0] opcode_i;
  logic [2:0] func3_i;
  logic [6:0] func7_i;
  logic [31:0] operand_A_i;
  logic [31:0] operand_B_i;
  logic [31:0] DT_i;
  logic [31:0] address_i;
  logic [31:0] result_o;
  logic [31:0] DT_o;
  logic [5:0] ALUop_o;
  logic I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o, LUI_EN_o, RWR_EN_o;
  logic BE_o, JALRE_o, UJE_o, IWR_EN_o, IR_EN_o, DWR_EN_o, DR_EN_o, regrst_o, PCrst_o;
  modport master (
    output opcode_i, func3_i, func7_i, operand_A_i, operand_B_i, DT_i, address_i,
    input result_o, DT_o, ALUop_o, I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o, LUI_EN_o,
    input RWR_EN_o, BE_o, JALRE_o, UJE_o, IWR_EN_o, IR_EN_o, DWR_EN_o, DR_EN_o, regrst_o, PCrst_o
  );
  modport slave (
    input opcode_i, func3_i, func7_i, operand_A_i, operand_B_i, DT_i, address_i,
    output result_o, DT_o, ALUop_o, I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o, LUI_EN_o,
    output RWR_EN_o, BE_o, JALRE_o, UJE_o, IWR_EN_o, IR_EN_o, DWR_EN_o, DR_EN_o, regrst_o, PCrst_o
  );
endinterface

// File: rtl/rv32i_ctrl_alu_dmem.sv
// rv32i_ctrl_alu_dmem: RV32I execute cluster -- main control decoder, ALU and byte-lane data memory
// ports: clk_i, rst_i (sync active-high) and bus (slave modport: decoded fields/operands in, control/result/load data out)
module rv32i_ctrl_alu_dmem #(
  parameter int DMEM_WORDS = 1024
) (
  input logic clk_i,
  input logic rst_i,
  rv32i_ctrl_alu_dmem_if.slave bus
);
  localparam int AW = $clog2(DMEM_WORDS);
  localparam logic [5:0] NOP = 6'd63;
  logic r_rst;
  logic [31:0] r_mem [DMEM_WORDS];
  logic [11:0] w_en;
  logic [5:0] w_f3op, w_op;
  logic [31:0] w_a, w_b, w_res, w_rd;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic [AW-1:0] w_idx;
  logic w_unused;
  assign w_a = bus.operand_A_i;
  assign w_b = bus.operand_B_i;
  assign w_unused = &{1'b0, bus.func7_i[6], bus.func7_i[4:0], bus.address_i[31:AW+2]};
  always_ff @(posedge clk_i) r_rst <= rst_i;
  always_comb begin
    case (bus.func3_i)
      3'd0: w_f3op = 6'd0;
      3'd1: w_f3op = 6'd2;
      3'd2: w_f3op = 6'd3;
      3'd3: w_f3op = 6'd4;
      3'd4: w_f3op = 6'd5;
      3'd5: w_f3op = bus.func7_i[5] ? 6'd7 : 6'd6;
      3'd6: w_f3op = 6'd8;
      default: w_f3op = 6'd9;
    endcase
  end
  // w_en = {I,R,S,SB,U,UJ,LUI,RWR,JALRE,UJE,DWR,DR}
  always_comb begin
    w_en = '0;
    w_op = NOP;
    case (bus.opcode_i)
      7'b0110011: begin w_en = 12'b0100_0001_0000; w_op = (bus.func3_i == 3'd0 && bus.func7_i[5]) ? 6'd1 : w_f3op; end
      7'b0010011: begin w_en = 12'b1000_0001_0000; w_op = w_f3op; end
      7'b0000011: begin w_en = 12'b1000_0001_0001; w_op = 6'd0; end
      7'b0100011: begin w_en = 12'b0010_0000_0010; w_op = 6'd0; end
      7'b1100011: begin
        w_en = 12'b0001_0000_0000;
        w_op = bus.func3_i[2:1] == 2'b01 ? NOP : bus.func3_i[2] ? {4'd3, bus.func3_i[1:0]} : {5'd5, bus.func3_i[0]};
      end
      7'b0110111: begin w_en = 12'b0000_1011_0000; w_op = 6'd16; end
      7'b0010111: begin w_en = 12'b0000_1001_0000; w_op = 6'd16; end
      7'b1101111: w_en = 12'b0000_0101_0100;
      7'b1100111: begin w_en = 12'b1000_0001_1000; w_op = 6'd0; end
      default: ;
    endcase
    if (r_rst) begin
      w_en = '0;
      w_op = NOP;
    end
  end
  always_comb begin
    case (w_op)
      6'd0: w_res = w_a + w_b;
      6'd1: w_res = w_a - w_b;
      6'd2: w_res = w_a << w_b[4:0];
      6'd3, 6'd12: w_res = {31'd0, $signed(w_a) < $signed(w_b)};
      6'd4, 6'd14: w_res = {31'd0, w_a < w_b};
      6'd5: w_res = w_a ^ w_b;
      6'd6: w_res = w_a >> w_b[4:0];
      6'd7: w_res = $signed(w_a) >>> w_b[4:0];
      6'd8: w_res = w_a | w_b;
      6'd9: w_res = w_a & w_b;
      6'd10: w_res = {31'd0, w_a == w_b};
      6'd11: w_res = {31'd0, w_a != w_b};
      6'd13: w_res = {31'd0, $signed(w_a) >= $signed(w_b)};
      6'd15: w_res = {31'd0, w_a >= w_b};
      6'd16: w_res = w_b;
      default: w_res = '0;
    endcase
  end
  assign w_idx = bus.address_i[AW+1:2];
  assign w_rd = r_mem[w_idx];
  assign w_byte = w_rd[{bus.address_i[1:0], 3'b000} +: 8];
  assign w_half = w_rd[{bus.address_i[1], 4'b0000} +: 16];
  always_ff @(posedge clk_i) begin
    if (w_en[1])
      case (bus.func3_i)
        3'd0: r_mem[w_idx][{bus.address_i[1:0], 3'b000} +: 8] <= bus.DT_i[7:0];
        3'd1: r_mem[w_idx][{bus.address_i[1], 4'b0000} +: 16] <= bus.DT_i[15:0];
        3'd2: r_mem[w_idx] <= bus.DT_i;
        default: ;
      endcase
  end
  assign bus.DT_o = !w_en[0] ? '0 :
                    bus.func3_i == 3'd0 ? {{24{w_byte[7]}}, w_byte} :
                    bus.func3_i == 3'd1 ? {{16{w_half[15]}}, w_half} :
                    bus.func3_i == 3'd2 ? w_rd :
                    bus.func3_i == 3'd4 ? {24'd0, w_byte} :
                    bus.func3_i == 3'd5 ? {16'd0, w_half} : '0;
  assign {bus.I_EN_o, bus.R_EN_o, bus.S_EN_o, bus.SB_EN_o, bus.U_EN_o, bus.UJ_EN_o, bus.LUI_EN_o,
          bus.RWR_EN_o, bus.JALRE_o, bus.UJE_o, bus.DWR_EN_o, bus.DR_EN_o} = w_en;
  assign bus.ALUop_o = w_op;
  assign bus.result_o = w_res;
  assign bus.BE_o = w_en[8] & w_res[0];
  assign bus.IR_EN_o = !r_rst;
  assign bus.IWR_EN_o = 1'b0;
  assign bus.regrst_o = r_rst;
  assign bus.PCrst_o = r_rst;
endmodule

// File: tb/tb_rv32i_ctrl_alu_dmem.sv
// tb_rv32i_ctrl_alu_dmem: table-driven directed check of control, ALU and data memory
module tb_rv32i_ctrl_alu_dmem;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  rv32i_ctrl_alu_dmem_if bus();
  rv32i_ctrl_alu_dmem #(.DMEM_WORDS(1024)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [14:0] F_I = 15'h4000, F_R = 15'h2000, F_S = 15'h1000, F_SB = 15'h0800;
  localparam logic [14:0] F_U = 15'h0400, F_UJ = 15'h0200, F_LUI = 15'h0100, F_RWR = 15'h0080;
  localparam logic [14:0] F_BE = 15'h0040, F_JR = 15'h0020, F_UJE = 15'h0010, F_IWR = 15'h0008;
  localparam logic [14:0] F_IR = 15'h0004, F_DWR = 15'h0002, F_DR = 15'h0001;
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] a, b, dt, addr;
    logic [5:0] alu;
    logic [31:0] res, dto;
    logic [14:0] fl;
  } vec_t;
  vec_t v[$];
  function automatic logic [14:0] flags();
    return {bus.I_EN_o, bus.R_EN_o, bus.S_EN_o, bus.SB_EN_o, bus.U_EN_o, bus.UJ_EN_o, bus.LUI_EN_o,
            bus.RWR_EN_o, bus.BE_o, bus.JALRE_o, bus.UJE_o, bus.IWR_EN_o, bus.IR_EN_o, bus.DWR_EN_o, bus.DR_EN_o};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] dt, input logic [31:0] addr, input logic [5:0] alu,
                     input logic [31:0] res, input logic [31:0] dto, input logic [14:0] fl);
    vec_t t;
    t.op = op; t.f3 = f3; t.f7 = f7; t.a = a; t.b = b; t.dt = dt; t.addr = addr;
    t.alu = alu; t.res = res; t.dto = dto; t.fl = fl;
    v.push_back(t);
  endtask
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] dt, input logic [31:0] addr);
    bus.opcode_i = op; bus.func3_i = f3; bus.func7_i = 7'd0;
    bus.operand_A_i = a; bus.operand_B_i = b; bus.DT_i = dt; bus.address_i = addr;
  endtask
  localparam logic [14:0] RR = F_R | F_RWR | F_IR, II = F_I | F_RWR | F_IR, LD = F_I | F_RWR | F_DR | F_IR;
  localparam logic [14:0] ST = F_S | F_DWR | F_IR, BR = F_SB | F_IR, BT = F_SB | F_BE | F_IR;
  initial begin
    add(7'h33, 0, 7'h20, 5, 7, 0, 0, 1, 32'hFFFFFFFE, 0, RR);
    add(7'h33, 0, 7'h00, 5, 7, 0, 0, 0, 12, 0, RR);
    add(7'h33, 5, 7'h20, 32'h80000000, 4, 0, 0, 7, 32'hF8000000, 0, RR);
    add(7'h33, 5, 7'h00, 32'h80000000, 4, 0, 0, 6, 32'h08000000, 0, RR);
    add(7'h33, 2, 7'h00, 32'hFFFFFFFF, 1, 0, 0, 3, 1, 0, RR);
    add(7'h13, 0, 7'h20, 1, 2, 0, 0, 0, 3, 0, II);
    add(7'h13, 3, 7'h00, 1, 32'hFFFFFFFF, 0, 0, 4, 1, 0, II);
    add(7'h13, 1, 7'h00, 1, 31, 0, 0, 2, 32'h80000000, 0, II);
    add(7'h13, 4, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 5, 32'h0FF00FF0, 0, II);
    add(7'h13, 6, 7'h00, 32'hF0, 32'h0F, 0, 0, 8, 32'hFF, 0, II);
    add(7'h13, 7, 7'h00, 32'hF0, 32'h3C, 0, 0, 9, 32'h30, 0, II);
    add(7'h13, 5, 7'h20, 32'hFFFFFF00, 4, 0, 0, 7, 32'hFFFFFFF0, 0, II);
    add(7'h63, 4, 0, 32'hFFFFFFFF, 0, 0, 0, 12, 1, 0, BT);
    add(7'h63, 6, 0, 32'hFFFFFFFF, 0, 0, 0, 14, 0, 0, BR);
    add(7'h63, 0, 0, 9, 9, 0, 0, 10, 1, 0, BT);
    add(7'h63, 1, 0, 9, 9, 0, 0, 11, 0, 0, BR);
    add(7'h63, 5, 0, 32'hFFFFFFFF, 0, 0, 0, 13, 0, 0, BR);
    add(7'h63, 7, 0, 32'hFFFFFFFF, 0, 0, 0, 15, 1, 0, BT);
    add(7'h23, 2, 0, 0, 8, 32'h12345680, 8, 0, 8, 0, ST);
    add(7'h03, 0, 0, 0, 8, 0, 8, 0, 8, 32'hFFFFFF80, LD);
    add(7'h03, 4, 0, 0, 8, 0, 8, 0, 8, 32'h00000080, LD);
    add(7'h23, 0, 0, 0, 9, 32'h0000007F, 9, 0, 9, 0, ST);
    add(7'h03, 2, 0, 0, 8, 0, 8, 0, 8, 32'h12347F80, LD);
    add(7'h03, 1, 0, 0, 8, 0, 8, 0, 8, 32'h00007F80, LD);
    add(7'h23, 1, 0, 0, 10, 32'h0000ABCD, 10, 0, 10, 0, ST);
    add(7'h03, 1, 0, 0, 10, 0, 10, 0, 10, 32'hFFFFABCD, LD);
    add(7'h03, 5, 0, 0, 10, 0, 10, 0, 10, 32'h0000ABCD, LD);
    add(7'h03, 2, 0, 0, 11, 0, 11, 0, 11, 32'hABCD7F80, LD);
    add(7'h7F, 2, 0, 1, 2, 32'hDEADBEEF, 8, 63, 0, 0, F_IR);
    add(7'h03, 2, 0, 0, 8, 0, 8, 0, 8, 32'hABCD7F80, LD);
    add(7'h37, 0, 0, 5, 32'hABCDE000, 0, 0, 16, 32'hABCDE000, 0, F_U | F_LUI | F_RWR | F_IR);
    add(7'h17, 0, 0, 5, 32'h1000, 0, 0, 16, 32'h1000, 0, F_U | F_RWR | F_IR);
    add(7'h6F, 0, 0, 5, 6, 0, 0, 63, 0, 0, F_UJ | F_UJE | F_RWR | F_IR);
    add(7'h67, 0, 0, 100, 4, 0, 0, 0, 104, 0, F_I | F_JR | F_RWR | F_IR);
    add(7'h23, 2, 0, 0, 32'h1004, 32'h55AA55AA, 32'h1004, 0, 32'h1004, 0, ST);
    add(7'h03, 2, 0, 0, 4, 0, 4, 0, 4, 32'h55AA55AA, LD);
    add(7'h23, 3, 0, 0, 4, 32'h0, 4, 0, 4, 0, ST);
    add(7'h03, 2, 0, 0, 4, 0, 4, 0, 4, 32'h55AA55AA, LD);
    add(7'h03, 3, 0, 0, 4, 0, 4, 0, 4, 32'h0, LD);
    drive(7'h33, 0, 5, 7, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regrst", bus.regrst_o, 1);
    chk("rst_pcrst", bus.PCrst_o, 1);
    chk("rst_flags", flags(), 0);
    chk("rst_aluop", bus.ALUop_o, 63);
    rst = 0;
    #4;
    chk("rel_hold_regrst", bus.regrst_o, 1);
    @(posedge clk);
    #1;
    chk("rel_regrst", bus.regrst_o, 0);
    chk("rel_pcrst", bus.PCrst_o, 0);
    chk("rel_flags", flags(), RR);
    foreach (v[i]) begin
      @(posedge clk);
      #1;
      drive(v[i].op, v[i].f3, v[i].a, v[i].b, v[i].dt, v[i].addr);
      bus.func7_i = v[i].f7;
      #4;
      chk($sformatf("v%0d_flags", i), flags(), v[i].fl);
      chk($sformatf("v%0d_aluop", i), bus.ALUop_o, v[i].alu);
      chk($sformatf("v%0d_result", i), bus.result_o, v[i].res);
      chk($sformatf("v%0d_dt", i), bus.DT_o, v[i].dto);
    end
    @(posedge clk);
    #1;
    drive(7'h23, 2, 0, 12, 32'h11111111, 12);
    @(posedge clk);
    #1;
    rst = 1;
    drive(7'h03, 2, 0, 12, 0, 12);
    @(posedge clk);
    #1;
    drive(7'h23, 2, 0, 12, 32'h22222222, 12);
    #4;
    chk("rst_store_gated", flags(), 0);
    @(posedge clk);
    #1;
    rst = 0;
    drive(7'h03, 2, 0, 12, 0, 12);
    @(posedge clk);
    #1;
    chk("rst_mem_kept", bus.DT_o, 32'h11111111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
